// File: rtl/traffic_light_controller_param.sv
// Two-road intersection controller with parameterised phase lengths.
// All-red clearance follows each yellow. Pedestrian requests are latched.
// Flash (night/fault) mode is entered only at an all-red exit.
// The controller steps once per new_clk edge. The lamps are a pure decode of the state and blink registers.
module traffic_light_controller_param #(
    parameter int CNT_W    = 4,
    parameter int MG_MIN   = 6,
    parameter int MG_MAX   = 12,
    parameter int EXT_LEN  = 3,
    parameter int Y_LEN    = 2,
    parameter int AR_LEN   = 1,
    parameter int WALK_LEN = 3,
    parameter int SG_LEN   = 6
) (
    input  logic       new_clk,
    input  logic       rst,
    input  logic       walk_button,
    input  logic       sensor,
    input  logic       flash,
    output logic       main_green,
    output logic       main_yellow,
    output logic       main_red,
    output logic       side_green,
    output logic       side_yellow,
    output logic       side_red,
    output logic       walk_lamp,
    output logic       walk_pending,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        S_MAIN_GREEN  = 4'd0,
        S_MAIN_EXT    = 4'd1,
        S_MAIN_YELLOW = 4'd2,
        S_ALL_RED_1   = 4'd3,
        S_WALK        = 4'd4,
        S_SIDE_GREEN  = 4'd5,
        S_SIDE_EXT    = 4'd6,
        S_SIDE_YELLOW = 4'd7,
        S_ALL_RED_2   = 4'd8,
        S_FLASH       = 4'd9
    } state_e;

    localparam int CAP = 1 << CNT_W;

    // Each constant is the final cnt value of its phase.
    // The phase exits on the edge where cnt equals it.
    localparam logic [CNT_W-1:0] MG_MIN_LAST = CNT_W'(MG_MIN - 1);
    localparam logic [CNT_W-1:0] MG_MAX_LAST = CNT_W'(MG_MAX - 1);
    localparam logic [CNT_W-1:0] EXT_LAST    = CNT_W'(EXT_LEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST      = CNT_W'(Y_LEN - 1);
    localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(AR_LEN - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_LEN - 1);
    localparam logic [CNT_W-1:0] SG_LAST     = CNT_W'(SG_LEN - 1);

    // Reject parameter sets the counter or the green logic cannot honour.
    if (!(MG_MIN < MG_MAX)) begin : g_chk_mg
        $error("MG_MIN must be less than MG_MAX");
    end
    if (MG_MIN < 1 || EXT_LEN < 1 || Y_LEN < 1 || AR_LEN < 1 ||
        WALK_LEN < 1 || SG_LEN < 1) begin : g_chk_min
        $error("every phase length must be at least 1");
    end
    if (MG_MAX > CAP || EXT_LEN > CAP || Y_LEN > CAP || AR_LEN > CAP ||
        WALK_LEN > CAP || SG_LEN > CAP) begin : g_chk_max
        $error("a phase length exceeds the range of the CNT_W counter");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               walk_req_q, walk_req_d;
    logic               blink_q, blink_d;

    // State, counter, walk latch and blink registers; reset restarts main green.
    always_ff @(posedge new_clk) begin
        if (rst) begin
            state_q    <= S_MAIN_GREEN;
            cnt_q      <= '0;
            walk_req_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            walk_req_q <= walk_req_d;
            blink_q    <= blink_d;
        end
    end

    // Next-state logic. Any state change zeroes cnt; otherwise cnt counts up.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        blink_d    = 1'b0;
        walk_req_d = walk_req_q;

        case (state_q)
            S_MAIN_GREEN: begin
                // The sensor only matters on the minimum-green boundary.
                if (cnt_q == MG_MIN_LAST && sensor) begin
                    state_d = S_MAIN_EXT;
                    cnt_d   = '0;
                end else if (cnt_q == MG_MAX_LAST) begin
                    state_d = S_MAIN_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_MAIN_EXT: begin
                if (cnt_q == EXT_LAST) begin
                    state_d = S_MAIN_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_MAIN_YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    state_d = S_ALL_RED_1;
                    cnt_d   = '0;
                end
            end
            S_ALL_RED_1: begin
                if (cnt_q == AR_LAST) begin
                    cnt_d = '0;
                    if (flash)
                        state_d = S_FLASH;
                    else if (walk_req_q)
                        state_d = S_WALK;
                    else
                        state_d = S_SIDE_GREEN;
                end
            end
            S_WALK: begin
                if (cnt_q == WALK_LAST) begin
                    state_d = S_SIDE_GREEN;
                    cnt_d   = '0;
                end
            end
            S_SIDE_GREEN: begin
                if (cnt_q == SG_LAST) begin
                    state_d = sensor ? S_SIDE_EXT : S_SIDE_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_SIDE_EXT: begin
                if (cnt_q == EXT_LAST) begin
                    state_d = S_SIDE_YELLOW;
                    cnt_d   = '0;
                end
            end
            S_SIDE_YELLOW: begin
                if (cnt_q == Y_LAST) begin
                    state_d = S_ALL_RED_2;
                    cnt_d   = '0;
                end
            end
            S_ALL_RED_2: begin
                if (cnt_q == AR_LAST) begin
                    state_d = flash ? S_FLASH : S_MAIN_GREEN;
                    cnt_d   = '0;
                end
            end
            S_FLASH: begin
                // Leaving flash goes through a full all-red before main green.
                if (!flash) begin
                    state_d = S_ALL_RED_2;
                    cnt_d   = '0;
                end else begin
                    blink_d = ~blink_q;
                end
            end
            default: begin
                // Corrupted state code: recover through all-red.
                state_d = S_ALL_RED_2;
                cnt_d   = '0;
            end
        endcase

        // Entering WALK serves the request, and the clear beats a simultaneous press.
        if (state_d == S_WALK && state_q != S_WALK)
            walk_req_d = 1'b0;
        else if (walk_button && state_q != S_WALK)
            walk_req_d = 1'b1;
    end

    // Lamp decode from the current state, plus blink while flashing.
    always_comb begin
        main_green  = 1'b0;
        main_yellow = 1'b0;
        main_red    = 1'b0;
        side_green  = 1'b0;
        side_yellow = 1'b0;
        side_red    = 1'b0;
        walk_lamp   = 1'b0;
        case (state_q)
            S_MAIN_GREEN, S_MAIN_EXT: begin
                main_green = 1'b1;
                side_red   = 1'b1;
            end
            S_MAIN_YELLOW: begin
                main_yellow = 1'b1;
                side_red    = 1'b1;
            end
            S_ALL_RED_1, S_ALL_RED_2: begin
                main_red = 1'b1;
                side_red = 1'b1;
            end
            S_WALK: begin
                main_red  = 1'b1;
                side_red  = 1'b1;
                walk_lamp = 1'b1;
            end
            S_SIDE_GREEN, S_SIDE_EXT: begin
                main_red   = 1'b1;
                side_green = 1'b1;
            end
            S_SIDE_YELLOW: begin
                main_red    = 1'b1;
                side_yellow = 1'b1;
            end
            S_FLASH: begin
                main_yellow = blink_q;
                side_red    = blink_q;
            end
            default: begin
                main_green = 1'b0;
            end
        endcase
    end

    assign walk_pending = walk_req_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Directed bench for traffic_light_controller_param.
// Each cycle's expected lamps, phase and walk_pending are queued up front.
// They are popped and compared once per cycle, #1 after the edge.
module tb_traffic_light_controller_param;

    logic       new_clk, rst, walk_button, sensor, flash;
    logic       main_green, main_yellow, main_red;
    logic       side_green, side_yellow, side_red;
    logic       walk_lamp, walk_pending;
    logic [3:0] phase;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected entry layout: {phase[3:0], mg, my, mr, sg, sy, sr, walk, walk_pending}.
    logic [11:0] exp_q[$];
    string       tag_q[$];

    localparam logic [6:0] L_MG = 7'b1000010;
    localparam logic [6:0] L_MY = 7'b0100010;
    localparam logic [6:0] L_AR = 7'b0010010;
    localparam logic [6:0] L_WK = 7'b0010011;
    localparam logic [6:0] L_SG = 7'b0011000;
    localparam logic [6:0] L_SY = 7'b0010100;
    localparam logic [6:0] L_FO = 7'b0000000;

    traffic_light_controller_param dut (
        .new_clk      (new_clk),
        .rst          (rst),
        .walk_button  (walk_button),
        .sensor       (sensor),
        .flash        (flash),
        .main_green   (main_green),
        .main_yellow  (main_yellow),
        .main_red     (main_red),
        .side_green   (side_green),
        .side_yellow  (side_yellow),
        .side_red     (side_red),
        .walk_lamp    (walk_lamp),
        .walk_pending (walk_pending),
        .phase        (phase)
    );

    initial begin
        new_clk = 1'b0;
        forever #5 new_clk = ~new_clk;
    end

    task automatic push(input string tag, input logic [3:0] ph, input logic [6:0] lamps,
                        input logic wp, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({ph, lamps, wp});
            tag_q.push_back(tag);
        end
    endtask

    // Check the current cycle against the next queued expectation, then advance one edge.
    task automatic run(input int n);
        logic [11:0] obs, exp;
        string       tag;
        for (int i = 0; i < n; i++) begin
            obs = {phase, main_green, main_yellow, main_red, side_green, side_yellow,
                   side_red, walk_lamp, walk_pending};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $error("FAIL underflow: got %h expected <queued entry>", obs);
            end else begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                assert (obs === exp) else begin
                    tests_failed++;
                    $error("FAIL %s (t=%0t): got %h expected %h", tag, $time, obs, exp);
                end
            end
            @(posedge new_clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; walk_button = 1'b0; sensor = 1'b0; flash = 1'b0;
        @(posedge new_clk); #1;
        @(posedge new_clk); #1;
        rst = 1'b0;

        // Two idle periods: 12+2+1+6+2+1, the first cycle being the reset state.
        for (int p = 0; p < 2; p++) begin
            push("idle_mg", 4'd0, L_MG, 1'b0, 12);
            push("idle_my", 4'd2, L_MY, 1'b0, 2);
            push("idle_ar1", 4'd3, L_AR, 1'b0, 1);
            push("idle_sg", 4'd5, L_SG, 1'b0, 6);
            push("idle_sy", 4'd7, L_SY, 1'b0, 2);
            push("idle_ar2", 4'd8, L_AR, 1'b0, 1);
        end
        run(48);

        // Sensor at main-green cnt 5 gives a 6+3 main green.
        push("mext_mg", 4'd0, L_MG, 1'b0, 6);
        push("mext_ext", 4'd1, L_MG, 1'b0, 3);
        push("mext_my", 4'd2, L_MY, 1'b0, 2);
        push("mext_ar1", 4'd3, L_AR, 1'b0, 1);
        push("mext_sg", 4'd5, L_SG, 1'b0, 6);
        push("mext_sy", 4'd7, L_SY, 1'b0, 2);
        push("mext_ar2", 4'd8, L_AR, 1'b0, 1);
        run(5); sensor = 1'b1; run(1); sensor = 1'b0; run(15);

        // Walk request at cnt 2 is served after all-red.
        // Presses entering and during WALK are dropped. Side green is extended by the sensor.
        push("walk_mg0", 4'd0, L_MG, 1'b0, 3);
        push("walk_mg1", 4'd0, L_MG, 1'b1, 9);
        push("walk_my", 4'd2, L_MY, 1'b1, 2);
        push("walk_ar1", 4'd3, L_AR, 1'b1, 1);
        push("walk_walk", 4'd4, L_WK, 1'b0, 3);
        push("walk_sg", 4'd5, L_SG, 1'b0, 6);
        push("walk_sext", 4'd6, L_SG, 1'b0, 3);
        push("walk_sy", 4'd7, L_SY, 1'b0, 2);
        push("walk_ar2", 4'd8, L_AR, 1'b0, 1);
        run(2); walk_button = 1'b1; run(1); walk_button = 1'b0;
        run(9); run(2);
        walk_button = 1'b1; run(1); run(3); walk_button = 1'b0;
        run(5); sensor = 1'b1; run(1); sensor = 1'b0; run(6);

        // Flash raised mid-green waits for ALL_RED_1.
        // Flash beats a pending walk, and the walk request survives flash.
        push("fl_mg0", 4'd0, L_MG, 1'b0, 2);
        push("fl_mg1", 4'd0, L_MG, 1'b1, 10);
        push("fl_my", 4'd2, L_MY, 1'b1, 2);
        push("fl_ar1", 4'd3, L_AR, 1'b1, 1);
        push("fl_off0", 4'd9, L_FO, 1'b1, 1);
        push("fl_on0", 4'd9, L_MY, 1'b1, 1);
        push("fl_off1", 4'd9, L_FO, 1'b1, 1);
        push("fl_on1", 4'd9, L_MY, 1'b1, 1);
        push("fl_ar2", 4'd8, L_AR, 1'b1, 1);
        push("fl_mg2", 4'd0, L_MG, 1'b1, 12);
        push("fl_my2", 4'd2, L_MY, 1'b1, 2);
        push("fl_ar1b", 4'd3, L_AR, 1'b1, 1);
        push("fl_walk", 4'd4, L_WK, 1'b0, 2);
        run(1); walk_button = 1'b1; run(1); walk_button = 1'b0; run(1);
        flash = 1'b1; run(15); flash = 1'b0; run(1);
        run(17);
        // Reset in the middle of WALK restarts main green immediately.
        rst = 1'b1; run(1); rst = 1'b0;

        // Reset also drops a latched walk request, and the count restarts from 0.
        push("rst_mg0", 4'd0, L_MG, 1'b0, 3);
        push("rst_mg1", 4'd0, L_MG, 1'b1, 3);
        push("rst2_mg", 4'd0, L_MG, 1'b0, 12);
        push("rst2_my", 4'd2, L_MY, 1'b0, 2);
        push("rst2_ar1", 4'd3, L_AR, 1'b0, 1);
        run(2); walk_button = 1'b1; run(1); walk_button = 1'b0; run(2);
        rst = 1'b1; run(1); rst = 1'b0;
        run(15);

        tests_run++;
        assert (exp_q.size() === 0) else begin
            tests_failed++;
            $error("FAIL leftover: got %0d queued expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
